// File: rtl/sim_exit_reporter.sv
// ---------------------------------------------------------------------------
// sim_exit_reporter
//
// Purpose:
//   End-of-test reporter for simulation. Accepts a single exit code from the
//   test harness over a valid/ready handshake, waits DRAIN_CYCLES cycles so
//   in-flight activity can settle, then raises a sticky done. An optional
//   watchdog substitutes an all-ones failure code if no code arrives within
//   TIMEOUT_CYCLES cycles of reset release. Outside synthesis the block
//   prints one result line when done first reads 1 and, if FINISH is set,
//   ends the run ($finish on code 0, $fatal otherwise).
//
// Ports:
//   clock        in   1           sole clock
//   reset        in   1           asynchronous, active-high reset
//   req_valid    in   1           harness presents an exit code
//   req_ready    out  1           block can accept a code (RUN only)
//   req_code     in   CODE_WIDTH  exit code, taken when valid && ready
//   done         out  1           sticky, test has ended
//   exit_code    out  CODE_WIDTH  latched exit code
//   timed_out    out  1           sticky, watchdog supplied the code
//   cycle_count  out  64          cycles since reset release (saturating)
// ---------------------------------------------------------------------------
module sim_exit_reporter #(
    parameter int unsigned CODE_WIDTH     = 32,
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd0,
    parameter bit          FINISH         = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CODE_WIDTH-1:0] req_code,
    output logic                  done,
    output logic [CODE_WIDTH-1:0] exit_code,
    output logic                  timed_out,
    output logic [63:0]           cycle_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES);
    localparam bit          WD_EN      = (TIMEOUT_CYCLES != 64'd0);
    // The watchdog fires on the edge that would bring cycle_count up to the
    // timeout, i.e. while the current count is one below it.
    localparam logic [63:0] WD_LAST    = TIMEOUT_CYCLES - 64'd1;

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic [CODE_WIDTH-1:0]   exit_code_q, exit_code_d;
    logic                    timed_out_q, timed_out_d;
    logic [63:0]             cycle_count_q, cycle_count_d;
    logic [15:0]             drain_q, drain_d;
    logic [63:0]             cycle_count_inc;
    logic                    accept;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cycle_count_inc = (cycle_count_q == '1) ? cycle_count_q
                                                   : cycle_count_q + 64'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            done_q        <= 1'b0;
            exit_code_q   <= '0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= '0;
            drain_q       <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            exit_code_q   <= exit_code_d;
            timed_out_q   <= timed_out_d;
            cycle_count_q <= cycle_count_d;
            drain_q       <= drain_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        exit_code_d   = exit_code_q;
        timed_out_d   = timed_out_q;
        cycle_count_d = cycle_count_q;
        drain_d       = drain_q;
        accept        = 1'b0;

        case (state_q)
            RUN: begin
                cycle_count_d = cycle_count_inc;
                if (req_valid) begin
                    // A real code always beats a watchdog firing on the same edge.
                    accept      = 1'b1;
                    exit_code_d = req_code;
                end else if (WD_EN && (cycle_count_q == WD_LAST)) begin
                    accept      = 1'b1;
                    exit_code_d = '1;
                    timed_out_d = 1'b1;
                end
                if (accept) begin
                    if (DRAIN_CYCLES != 0) begin
                        drain_d = DRAIN_LOAD;
                        state_d = DRAIN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                cycle_count_d = cycle_count_inc;
                drain_d       = drain_q - 16'd1;
                // <= 1 rather than == 1 so a corrupted zero cannot wedge DRAIN.
                if (drain_q <= 16'd1) begin
                    drain_d = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                // Terminal: everything frozen until reset.
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign req_ready   = (state_q == RUN);
    assign done        = done_q;
    assign exit_code   = exit_code_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;

`ifndef SYNTHESIS
    // Report once per reset epoch, at the clock edge that closes the first
    // cycle in which done reads 1.
    logic reported_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reported_q <= 1'b0;
        end else if (done_q && !reported_q) begin
            reported_q <= 1'b1;
            if (timed_out_q) begin
                $display("sim_exit_reporter: exit_code=0x%h cycle_count=%0d TIMEOUT",
                         exit_code_q, cycle_count_q);
            end else begin
                $display("sim_exit_reporter: exit_code=0x%h cycle_count=%0d",
                         exit_code_q, cycle_count_q);
            end
            if (FINISH) begin
                if (exit_code_q == '0) begin
                    $finish;
                end else begin
                    $fatal(1, "sim_exit_reporter: nonzero exit code 0x%h", exit_code_q);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_exit_reporter.sv
// ---------------------------------------------------------------------------
// tb_sim_exit_reporter
//
// Four instances with different drain/watchdog settings share one stimulus
// stream. A behavioural model counts edges since reset release, remembers
// the accept edge E and the code, and derives every output from that:
//   req_ready = not yet accepted
//   done      = accepted and edges >= E + drain
//   cycle_cnt = min(edges, E + drain) once accepted, else edges
// Outputs are compared against the model on every falling edge, right after
// each asynchronous reset assertion, and at literal checkpoints.
// ---------------------------------------------------------------------------
module tb_sim_exit_reporter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_code = 32'd0;

    logic        rdy [4];
    logic        dn  [4];
    logic        to  [4];
    logic [31:0] ec  [4];
    logic [63:0] cc  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sim_exit_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(64'd0), .FINISH(1'b0)) u0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]), .req_code(req_code),
        .done(dn[0]), .exit_code(ec[0]), .timed_out(to[0]), .cycle_count(cc[0]));
    sim_exit_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(64'd0), .FINISH(1'b0)) u1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]), .req_code(req_code),
        .done(dn[1]), .exit_code(ec[1]), .timed_out(to[1]), .cycle_count(cc[1]));
    sim_exit_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(2), .TIMEOUT_CYCLES(64'd20), .FINISH(1'b0)) u2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]), .req_code(req_code),
        .done(dn[2]), .exit_code(ec[2]), .timed_out(to[2]), .cycle_count(cc[2]));
    sim_exit_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(8), .TIMEOUT_CYCLES(64'd0), .FINISH(1'b0)) u3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[3]), .req_code(req_code),
        .done(dn[3]), .exit_code(ec[3]), .timed_out(to[3]), .cycle_count(cc[3]));

    // ---------------- behavioural model ----------------
    int unsigned m_drain [4] = '{4, 0, 2, 8};
    int unsigned m_tmo   [4] = '{0, 0, 20, 0};
    int unsigned m_k     [4] = '{0, 0, 0, 0};
    int unsigned m_e     [4] = '{0, 0, 0, 0};
    bit          m_acc   [4] = '{0, 0, 0, 0};
    bit          m_to    [4] = '{0, 0, 0, 0};
    logic [31:0] m_code  [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_k[i] = 0; m_e[i] = 0; m_acc[i] = 1'b0; m_to[i] = 1'b0; m_code[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_k[i] = m_k[i] + 1;
                if (!m_acc[i]) begin
                    if (req_valid) begin
                        m_acc[i] = 1'b1; m_e[i] = m_k[i]; m_code[i] = req_code;
                    end else if (m_tmo[i] != 0 && m_k[i] == m_tmo[i]) begin
                        m_acc[i] = 1'b1; m_e[i] = m_k[i]; m_code[i] = 32'hFFFF_FFFF; m_to[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic        e_done;
            logic [63:0] e_cc;
            e_done = m_acc[i] && (m_k[i] >= m_e[i] + m_drain[i]);
            e_cc   = m_acc[i] ? 64'((m_k[i] < m_e[i] + m_drain[i]) ? m_k[i] : m_e[i] + m_drain[i])
                              : 64'(m_k[i]);
            chk($sformatf("%s.u%0d.req_ready", tag, i), 64'(rdy[i]), 64'(!m_acc[i]));
            chk($sformatf("%s.u%0d.done", tag, i), 64'(dn[i]), 64'(e_done));
            chk($sformatf("%s.u%0d.exit_code", tag, i), 64'(ec[i]), 64'(m_acc[i] ? m_code[i] : 32'd0));
            chk($sformatf("%s.u%0d.timed_out", tag, i), 64'(to[i]), 64'(m_to[i]));
            chk($sformatf("%s.u%0d.cycle_count", tag, i), cc[i], e_cc);
        end
    endtask

    always @(negedge clock) check_all("cyc");

    // ---------------- stimulus ----------------
    // step: present inputs, take one edge, return 1 time unit after it.
    task automatic step(input bit v, input logic [31:0] c);
        req_valid = v;
        req_code  = c;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, $urandom);
    endtask

    // Asserted mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check_all("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Pass path: code 0 on edge 10.
        idle(9);
        step(1'b1, 32'd0);                                   // edge 10
        chk("pass.u1.done_e10", 64'(dn[1]), 64'd1);
        chk("pass.u1.cc_e10", cc[1], 64'd10);
        idle(3);                                             // edge 13
        chk("pass.u0.done_e13", 64'(dn[0]), 64'd0);
        step(1'b0, 32'd0);                                   // edge 14
        chk("pass.u0.done_e14", 64'(dn[0]), 64'd1);
        chk("pass.u0.cc_e14", cc[0], 64'd14);
        idle(16);                                            // edge 30
        chk("pass.u0.cc_frozen", cc[0], 64'd14);
        chk("pass.u3.cc_frozen", cc[3], 64'd18);

        // Zero drain: code 5 on edge 3, later pulses with code 9 ignored.
        do_reset();
        idle(2);
        step(1'b1, 32'h5);                                   // edge 3
        chk("zd.u1.done_e3", 64'(dn[1]), 64'd1);
        chk("zd.u1.code_e3", 64'(ec[1]), 64'h5);
        chk("zd.u1.ready_e3", 64'(rdy[1]), 64'd0);
        idle(2);
        step(1'b1, 32'h9);
        step(1'b0, 32'h9);
        step(1'b1, 32'h9);                                   // edge 8
        chk("zd.u1.code_e8", 64'(ec[1]), 64'h5);
        chk("zd.u0.code_e8", 64'(ec[0]), 64'h5);

        // Watchdog: no valid at all.
        do_reset();
        idle(20);                                            // edge 20
        chk("wd.u2.code_e20", 64'(ec[2]), 64'hFFFF_FFFF);
        chk("wd.u2.to_e20", 64'(to[2]), 64'd1);
        chk("wd.u2.done_e20", 64'(dn[2]), 64'd0);
        chk("wd.u0.ready_e20", 64'(rdy[0]), 64'd1);
        idle(2);                                             // edge 22
        chk("wd.u2.done_e22", 64'(dn[2]), 64'd1);
        chk("wd.u2.cc_e22", cc[2], 64'd22);

        // Watchdog collision: real code on edge 20.
        do_reset();
        idle(19);
        step(1'b1, 32'h7);                                   // edge 20
        chk("wdc.u2.code_e20", 64'(ec[2]), 64'h7);
        chk("wdc.u2.to_e20", 64'(to[2]), 64'd0);
        idle(3);

        // Reset mid-drain on the 8-cycle instance.
        do_reset();
        idle(4);
        step(1'b1, 32'h3);                                   // edge 5
        idle(3);                                             // edge 8
        #3;
        reset = 1'b1;
        #1;
        chk("mid.u3.ready", 64'(rdy[3]), 64'd1);
        chk("mid.u3.done", 64'(dn[3]), 64'd0);
        chk("mid.u3.code", 64'(ec[3]), 64'd0);
        chk("mid.u3.cc", cc[3], 64'd0);
        check_all("async");
        @(negedge clock);
        reset = 1'b0;
        idle(1);
        step(1'b1, 32'h1);                                   // edge 2
        idle(7);                                             // edge 9
        chk("mid.u3.done_e9", 64'(dn[3]), 64'd0);
        step(1'b0, 32'h0);                                   // edge 10
        chk("mid.u3.done_e10", 64'(dn[3]), 64'd1);
        chk("mid.u3.code_e10", 64'(ec[3]), 64'h1);

        // Randomized epochs: first valid at a random edge (or never), then
        // random valid/code traffic that must be ignored.
        for (int ep = 0; ep < 40; ep++) begin
            int fv;
            int len;
            do_reset();
            fv  = $urandom_range(0, 30);
            len = $urandom_range(5, 40);
            for (int e = 1; e <= len; e++) begin
                bit          v;
                logic [31:0] c;
                c = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                if (fv == 0 || e < fv) v = 1'b0;
                else if (e == fv)      v = 1'b1;
                else                   v = 1'($urandom_range(0, 1));
                step(v, c);
            end
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
